// File: rtl/flit_arbiter.sv
// Round-robin flit arbiter with packet locking: grants one source per cycle,
// holds the grant for the length of a packet, and registers the winning flit.
module flit_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SEG_W   = 16,
  localparam int ID_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       req_valid,
  input  logic [NUM_SRC-1:0]       req_last,
  input  logic [NUM_SRC*SEG_W-1:0] req_hf,
  input  logic [NUM_SRC*SEG_W-1:0] req_bf,
  input  logic [NUM_SRC*SEG_W-1:0] req_tf,
  output logic [NUM_SRC-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic [3*SEG_W-1:0]       flit_out,
  output logic                     write_enable,
  output logic [ID_W-1:0]          grant_id,
  output logic                     locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [3*SEG_W-1:0] flit_q, flit_d;
  logic               we_q, we_d;
  logic [ID_W-1:0]    grant_q, grant_d;

  logic               sel_found;
  logic [ID_W-1:0]    sel_idx;
  logic [ID_W-1:0]    cand;
  logic               xfer;
  logic [ID_W-1:0]    xfer_id;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_SRC);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    xfer_id   = (state_q == LOCKED) ? owner_q : sel_idx;
    if (!reset && !fifo_full) begin
      if (state_q == LOCKED) begin
        req_ready[owner_q] = req_valid[owner_q];
        xfer               = req_valid[owner_q];
      end else begin
        req_ready[sel_idx] = sel_found;
        xfer               = sel_found;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    flit_d  = flit_q;
    grant_d = grant_q;
    we_d    = xfer;
    if (xfer) begin
      flit_d  = {req_tf[int'(xfer_id)*SEG_W +: SEG_W],
                 req_bf[int'(xfer_id)*SEG_W +: SEG_W],
                 req_hf[int'(xfer_id)*SEG_W +: SEG_W]};
      grant_d = xfer_id;
      last_d  = xfer_id;
      if (state_q == IDLE) begin
        if (!req_last[xfer_id]) begin
          state_d = LOCKED;
          owner_d = xfer_id;
        end
      end else if (req_last[xfer_id]) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= ID_W'(NUM_SRC - 1);
      flit_q  <= '0;
      we_q    <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      flit_q  <= flit_d;
      we_q    <= we_d;
      grant_q <= grant_d;
    end
  end

  assign flit_out     = flit_q;
  assign write_enable = we_q;
  assign grant_id     = grant_q;
  assign locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_flit_arbiter.sv
// Scoreboard bench for flit_arbiter: a packet-level reference model predicts
// grants and flits; a monitor pops expectations whenever write_enable is seen.
module tb_flit_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*W-1:0] req_hf = '0, req_bf = '0, req_tf = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_full = 1'b0;
  logic [3*W-1:0] flit_out;
  logic           write_enable;
  logic [1:0]     grant_id;
  logic           locked;

  flit_arbiter #(.NUM_SRC(N), .SEG_W(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_hf(req_hf), .req_bf(req_bf), .req_tf(req_tf), .req_ready(req_ready),
    .fifo_full(fifo_full), .flit_out(flit_out), .write_enable(write_enable),
    .grant_id(grant_id), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [47:0] flit;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: packet in progress, its owner, previous winner.
  bit   mdl_locked = 1'b0;
  int   mdl_owner  = 0;
  int   mdl_last   = N - 1;
  bit   use_fixed  = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modelPick(input logic [N-1:0] v, input logic f);
    if (f) return -1;
    if (mdl_locked) return v[mdl_owner] ? mdl_owner : -1;
    for (int k = 1; k <= N; k++) begin
      int c = (mdl_last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One cycle of stimulus: drive at negedge, check the accept strobe, and
  // record the flit the arbiter owes the FIFO after the next edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
    int   g;
    exp_t e;
    @(negedge clk);
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    for (int i = 0; i < N; i++) begin
      req_hf[i*W +: W] = W'($urandom);
      req_bf[i*W +: W] = W'($urandom);
      req_tf[i*W +: W] = W'($urandom);
    end
    if (use_fixed) begin
      req_hf[0 +: W] = 16'h1111;
      req_bf[0 +: W] = 16'h2222;
      req_tf[0 +: W] = 16'h3333;
    end
    #1;
    g = modelPick(v, f);
    checkOutput("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
    if (g >= 0) begin
      e.id   = g;
      e.flit = {req_tf[g*W +: W], req_bf[g*W +: W], req_hf[g*W +: W]};
      exp_q.push_back(e);
      if (!mdl_locked) begin
        mdl_last = g;
        if (!l[g]) begin
          mdl_locked = 1'b1;
          mdl_owner  = g;
        end
      end else if (l[g]) begin
        mdl_locked = 1'b0;
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '1;
    fifo_full = 1'b0;
    exp_q.delete();
    mdl_locked = 1'b0;
    mdl_owner  = 0;
    mdl_last   = N - 1;
    #1;
    checkOutput("rst_flit", 64'(flit_out), 64'd0);
    checkOutput("rst_we", 64'(write_enable), 64'd0);
    checkOutput("rst_grant", 64'(grant_id), 64'd0);
    checkOutput("rst_locked", 64'(locked), 64'd0);
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
  endtask

  task automatic expectAfterEdge(input string name, input logic [63:0] act_sel, input logic [63:0] exp);
    @(posedge clk);
    #2;
    case (act_sel)
      0: checkOutput(name, 64'(grant_id), exp);
      1: checkOutput(name, 64'(locked), exp);
      default: checkOutput(name, 64'(write_enable), exp);
    endcase
  endtask

  // Monitor: every write must match the oldest outstanding expectation,
  // and any expectation still outstanding after its edge is a lost flit.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (write_enable) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_write", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("grant_id", 64'(grant_id), 64'(e.id));
          checkOutput("flit_out", 64'(flit_out), 64'(e.flit));
        end
      end else if (exp_q.size() != 0) begin
        checkOutput("missing_write", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
      end
      checkOutput("locked", 64'(locked), 64'(mdl_locked));
    end
  end

  initial begin
    applyReset();

    // Round-robin over four single-flit sources starting at source 0.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'hF, 4'hF, 1'b0);
      expectAfterEdge("rr_seq", 0, 64'(i % 4));
    end

    // Three-flit packet from source 2 with source 1 waiting alongside.
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    expectAfterEdge("pkt_grant0", 0, 64'd2);
    applyStimulus(4'b0110, 4'b0000, 1'b0);
    expectAfterEdge("pkt_grant1", 0, 64'd2);
    applyStimulus(4'b0110, 4'b0100, 1'b0);
    expectAfterEdge("pkt_grant2", 0, 64'd2);
    applyStimulus(4'b0110, 4'b1111, 1'b0);
    expectAfterEdge("after_pkt", 0, 64'd1);

    // Source 0 alone with known segments.
    use_fixed = 1'b1;
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("fixed_flit", 64'(flit_out), 64'h333322221111);
    checkOutput("fixed_we", 64'(write_enable), 64'd1);
    use_fixed = 1'b0;

    // Back-pressure for three cycles in the middle of a packet from source 3.
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      checkOutput("full_ready", 64'(req_ready), 64'd0);
      expectAfterEdge("full_we", 2, 64'd0);
    end
    applyStimulus(4'b1001, 4'b1000, 1'b0);
    expectAfterEdge("resume_owner", 0, 64'd3);

    // Owner idles while another source is valid; the lock must hold.
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    expectAfterEdge("lock_src1", 1, 64'd1);
    applyStimulus(4'b1000, 4'b1000, 1'b0);
    applyStimulus(4'b1000, 4'b1000, 1'b0);
    expectAfterEdge("lock_hold", 1, 64'd1);
    applyStimulus(4'b1010, 4'b0010, 1'b0);
    expectAfterEdge("lock_release", 0, 64'd1);
    applyStimulus(4'b1000, 4'b1000, 1'b0);
    expectAfterEdge("then_src3", 0, 64'd3);

    // Reset in the middle of a packet, then restart from source 0.
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    applyReset();
    applyStimulus(4'b0011, 4'b0011, 1'b0);
    expectAfterEdge("post_rst_src0", 0, 64'd0);

    // Randomised traffic with occasional back-pressure and resets.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 149) == 0) applyReset();
      applyStimulus(N'($urandom), N'($urandom), ($urandom_range(0, 4) == 0));
    end

    applyStimulus('0, '0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_arbiter.md
FLIT_ARBITER -- requirements
Module: flit_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, the number of requesting packet sources (2..8).
REQ-002 The block SHALL have parameter SEG_W, default 16, the width of each head, body and tail segment.
REQ-003 The block SHALL have input clk, 1 bit, the clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have input req_valid, NUM_SRC bits: per-source flit-valid.
REQ-006 The block SHALL have input req_last, NUM_SRC bits: per-source flag, set when the presented flit ends a packet.
REQ-007 The block SHALL have input req_hf, NUM_SRC*SEG_W bits: head segments, source i at bits [i*SEG_W +: SEG_W].
REQ-008 The block SHALL have inputs req_bf and req_tf, NUM_SRC*SEG_W bits each: body and tail segments, packed the same way as req_hf.
REQ-009 The block SHALL have output req_ready, NUM_SRC bits, combinational: flit accept strobe per source.
REQ-010 The block SHALL have input fifo_full, 1 bit: downstream FIFO cannot reserve another entry.
REQ-011 The block SHALL have output flit_out, 3*SEG_W bits, registered: the flit {TF, BF, HF}.
REQ-012 The block SHALL have output write_enable, 1 bit, registered: FIFO write strobe.
REQ-013 The block SHALL have output grant_id, clog2(NUM_SRC) bits, registered: the source of the current flit_out.
REQ-014 The block SHALL have output locked, 1 bit, registered: a packet is in progress.

Function
REQ-015 A transfer from source i SHALL occur in a cycle when req_valid[i]=1 and req_ready[i]=1.
REQ-016 At most one req_ready bit SHALL be high in any cycle.
REQ-017 All req_ready bits SHALL be 0 while fifo_full=1.
REQ-018 On a transfer from source i, the next edge SHALL load flit_out={req_tf[i],req_bf[i],req_hf[i]}, set write_enable=1 and set grant_id=i.
REQ-019 write_enable SHALL be 0 in any cycle following a cycle with no transfer; flit_out and grant_id SHALL then hold their values.
REQ-020 Latency from transfer to write_enable SHALL be exactly 1 cycle; sustained throughput SHALL be 1 flit per cycle while fifo_full=0.
REQ-021 The block SHALL implement a two-state machine, IDLE and LOCKED, exposed on locked (1 in LOCKED).
REQ-022 In IDLE, req_ready SHALL go to the first source with req_valid=1, searching round-robin from (last_winner+1) mod NUM_SRC.
REQ-023 In IDLE, a transfer with req_last=0 SHALL move the block to LOCKED, store owner=i and set last_winner=i.
REQ-024 In IDLE, a transfer with req_last=1 (a single-flit packet) SHALL leave the block in IDLE and set last_winner=i.
REQ-025 In LOCKED, only the owner SHALL be eligible for req_ready; other sources SHALL wait even when the owner's req_valid=0.
REQ-026 In LOCKED, an owner transfer with req_last=1 SHALL return the block to IDLE.
REQ-027 The round-robin pointer SHALL wrap from NUM_SRC-1 to 0.
REQ-028 fifo_full=1 in IDLE or LOCKED SHALL freeze the state and the pointer with no transfer; arbitration SHALL resume the first cycle fifo_full=0.
REQ-029 fifo_full SHALL be treated as a reservation signal: the write issued the cycle after a transfer SHALL be accepted by the FIFO regardless of fifo_full in that cycle.
REQ-030 req_last and segment inputs of non-granted sources SHALL be ignored.

Reset
REQ-031 While reset=1, the block SHALL hold flit_out=0, write_enable=0, grant_id=0, locked=0, state=IDLE, last_winner=NUM_SRC-1 (source 0 first) and req_ready=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet with no further writes; after release, arbitration SHALL restart from source 0.

Verification
REQ-033 Reset release, all four sources valid with req_last=1 continuously, fifo_full=0 -> grant_id 0,1,2,3,0 on consecutive write_enable cycles.
REQ-034 Source 2 sends a 3-flit packet (req_last on flit 3) while source 1 is valid throughout -> three consecutive writes from source 2, locked=1 across them, then source 3 is granted ahead of source 1 only if valid, otherwise source 1.
REQ-035 Source 0 has HF=16'h1111, BF=16'h2222, TF=16'h3333 and is the only valid source -> flit_out=48'h333322221111 with write_enable=1 one cycle after req_ready.
REQ-036 fifo_full=1 for 3 cycles mid-packet -> req_ready=0 and write_enable=0 for those cycles; the packet resumes with the same owner and no flit is lost or duplicated.
REQ-037 LOCKED to source 1 while its req_valid=0 for 2 cycles and source 3 is valid -> no grant to source 3 until source 1 completes its packet with req_last=1.
REQ-038 Reset asserted while locked=1 -> next cycle all outputs are 0; after release, with sources 0 and 1 valid, source 0 is granted first.
